// File: rtl/id_issue_queue.sv
// In-order queue of decoded entries between the decoder and the issue stage.
// It replaces the single ID/issue pipeline register, so a stalled issue stage
// no longer stalls fetch/decode right away. Optionally, only one control-flow
// instruction may wait in the queue at a time.
module id_issue_queue #(
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned Depth           = 4,
  parameter bit          BlockOnCtrlFlow = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         is_ctrl_flow_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DataWidth-1:0]         data_o,
  output logic                         is_ctrl_flow_o,
  output logic                         valid_o,
  input  logic                         ack_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = $clog2(Depth+1);

  logic [DataWidth-1:0] mem [Depth];
  logic [Depth-1:0]     cf_mem;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [CntWidth-1:0]  usage;
  logic [CntWidth-1:0]  cf_cnt;
  logic                 push;
  logic                 pop;
  logic                 ctrl_block;
  logic                 cf_inc;
  logic                 cf_dec;

  // Every output except ready_o comes straight from registers, so there is
  // no combinational path from data_i to data_o.
  assign empty_o        = (usage == '0);
  assign full_o         = (usage == CntWidth'(Depth));
  assign valid_o        = !empty_o;
  assign usage_o        = usage;
  assign data_o         = mem[rd_ptr];
  assign is_ctrl_flow_o = cf_mem[rd_ptr];

  // An ack while the queue is empty does not count as a pop.
  assign pop    = ack_i & valid_o;
  assign cf_inc = push & is_ctrl_flow_i;
  assign cf_dec = pop & is_ctrl_flow_o;

  // A queued control-flow entry holds off new pushes. The block lifts in the
  // cycle where the last such entry leaves, so that cycle can accept again.
  always_comb begin
    ctrl_block = 1'b0;
    if (BlockOnCtrlFlow) begin
      ctrl_block = (cf_cnt != '0) &&
                   !((cf_cnt == CntWidth'(1)) && pop && is_ctrl_flow_o);
    end
  end

  // A full queue still accepts when the head leaves in the same cycle, which
  // matches how the old single pipeline register behaved.
  assign ready_o = (!full_o || pop) && !ctrl_block;
  assign push    = valid_i & ready_o;

  // Entry storage. A push in a flush cycle is dropped, because the flush
  // discards it anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
      cf_mem <= '0;
    end else if (push && !flush_i) begin
      mem[wr_ptr]    <= data_i;
      cf_mem[wr_ptr] <= is_ctrl_flow_i;
    end
  end

  // Pointers and counters. Reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage  <= '0;
      cf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   usage <= usage + CntWidth'(1);
        2'b01:   usage <= usage - CntWidth'(1);
        default: usage <= usage;
      endcase
      case ({cf_inc, cf_dec})
        2'b10:   cf_cnt <= cf_cnt + CntWidth'(1);
        2'b01:   cf_cnt <= cf_cnt - CntWidth'(1);
        default: cf_cnt <= cf_cnt;
      endcase
    end
  end

  // Structural invariants of the queue.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full_o && !pop));
  a_usage_range: assert property (@(posedge clk_i) disable iff (rst_i)
    usage <= CntWidth'(Depth));
  a_cf_range: assert property (@(posedge clk_i) disable iff (rst_i)
    cf_cnt <= usage);

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue. It uses a table of directed vectors
// plus hand-written sequences for wrap, flush, ctrl-flow blocking and reset.
module tb_id_issue_queue;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, cf_in, valid_in, ack;
  logic [DW-1:0] data_in;
  logic          ready, cf_out, valid_out, full, empty;
  logic [DW-1:0] data_out;
  logic [2:0]    usage;

  logic          b_flush, b_cf_in, b_valid_in, b_ack;
  logic [DW-1:0] b_data_in;
  logic          b_ready, b_cf_out, b_valid_out, b_full, b_empty;
  logic [DW-1:0] b_data_out;
  logic [2:0]    b_usage;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_issue_queue #(.DataWidth(DW), .Depth(4), .BlockOnCtrlFlow(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data_in),
    .is_ctrl_flow_i(cf_in), .valid_i(valid_in), .ready_o(ready),
    .data_o(data_out), .is_ctrl_flow_o(cf_out), .valid_o(valid_out),
    .ack_i(ack), .usage_o(usage), .full_o(full), .empty_o(empty)
  );

  id_issue_queue #(.DataWidth(DW), .Depth(4), .BlockOnCtrlFlow(1'b1)) dut_blk (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .data_i(b_data_in),
    .is_ctrl_flow_i(b_cf_in), .valid_i(b_valid_in), .ready_o(b_ready),
    .data_o(b_data_out), .is_ctrl_flow_o(b_cf_out), .valid_o(b_valid_out),
    .ack_i(b_ack), .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty)
  );

  typedef struct {
    logic          flush;
    logic [DW-1:0] data;
    logic          cf;
    logic          valid;
    logic          ack;
    logic          exp_ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [2:0]    exp_usage;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [DW-1:0] d, input logic c,
                               input logic v, input logic a);
    @(negedge clk);
    flush = f; data_in = d; cf_in = c; valid_in = v; ack = a;
    #1;
  endtask

  task automatic applyBlk(input logic [DW-1:0] d, input logic c, input logic v, input logic a);
    @(negedge clk);
    b_flush = 1'b0; b_data_in = d; b_cf_in = c; b_valid_in = v; b_ack = a;
    #1;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] sb[$];
    logic [DW-1:0] next_val;
    logic          v, a, exp_rdy;
    int            pops, cyc;

    rst = 1'b1;
    flush = 0; data_in = '0; cf_in = 0; valid_in = 0; ack = 0;
    b_flush = 0; b_data_in = '0; b_cf_in = 0; b_valid_in = 0; b_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset valid", valid_out, 0);
    checkOutput("reset data", data_out, 0);
    checkOutput("reset cf", cf_out, 0);
    checkOutput("reset usage", usage, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset ready", ready, 1);

    // Fill, same-cycle replace when full, drain in order, then flush.
    vecs[0]  = '{0, 64'hA,  0, 1, 0, 1, 1, 64'hA, 3'd1, 0, 0};
    vecs[1]  = '{0, 64'hB,  0, 1, 0, 1, 1, 64'hA, 3'd2, 0, 0};
    vecs[2]  = '{0, 64'hC,  0, 1, 0, 1, 1, 64'hA, 3'd3, 0, 0};
    vecs[3]  = '{0, 64'hD,  0, 1, 0, 1, 1, 64'hA, 3'd4, 1, 0};
    vecs[4]  = '{0, 64'h99, 0, 1, 0, 0, 1, 64'hA, 3'd4, 1, 0};
    vecs[5]  = '{0, 64'hE,  0, 1, 1, 1, 1, 64'hB, 3'd4, 1, 0};
    vecs[6]  = '{0, 64'h0,  0, 0, 1, 1, 1, 64'hC, 3'd3, 0, 0};
    vecs[7]  = '{0, 64'h0,  0, 0, 1, 1, 1, 64'hD, 3'd2, 0, 0};
    vecs[8]  = '{0, 64'h0,  0, 0, 1, 1, 1, 64'hE, 3'd1, 0, 0};
    vecs[9]  = '{0, 64'h0,  0, 0, 1, 1, 0, 64'h0, 3'd0, 0, 1};
    vecs[10] = '{0, 64'hF1, 0, 1, 0, 1, 1, 64'hF1, 3'd1, 0, 0};
    vecs[11] = '{0, 64'hF2, 0, 1, 0, 1, 1, 64'hF1, 3'd2, 0, 0};
    vecs[12] = '{0, 64'hF3, 0, 1, 0, 1, 1, 64'hF1, 3'd3, 0, 0};
    vecs[13] = '{1, 64'h77, 0, 1, 1, 1, 0, 64'h0, 3'd0, 0, 1};
    vecs[14] = '{0, 64'h0,  0, 0, 0, 1, 0, 64'h0, 3'd0, 0, 1};
    vecs[15] = '{0, 64'h55, 0, 1, 0, 1, 1, 64'h55, 3'd1, 0, 0};
    vecs[16] = '{0, 64'h0,  0, 0, 1, 1, 0, 64'h0, 3'd0, 0, 1};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].data, vecs[i].cf, vecs[i].valid, vecs[i].ack);
      checkOutput($sformatf("v%0d ready", i), ready, vecs[i].exp_ready);
      afterEdge();
      checkOutput($sformatf("v%0d valid", i), valid_out, vecs[i].exp_valid);
      checkOutput($sformatf("v%0d usage", i), usage, vecs[i].exp_usage);
      checkOutput($sformatf("v%0d full", i), full, vecs[i].exp_full);
      checkOutput($sformatf("v%0d empty", i), empty, vecs[i].exp_empty);
      if (vecs[i].exp_valid)
        checkOutput($sformatf("v%0d data", i), data_out, vecs[i].exp_data);
    end

    // Random stalls on both sides against a FIFO model; 20 pops crosses the wrap several times.
    next_val = 64'h100;
    pops = 0;
    cyc = 0;
    while (pops < 20 && cyc < 400) begin
      cyc++;
      v = ($urandom_range(0, 3) != 0);
      a = (sb.size() != 0) && ($urandom_range(0, 2) != 0);
      applyStimulus(1'b0, next_val, 1'b0, v, a);
      exp_rdy = (sb.size() < 4) || a;
      checkOutput("t3 ready", ready, exp_rdy);
      if (a) begin
        checkOutput("t3 order", data_out, sb[0]);
        void'(sb.pop_front());
        pops++;
      end
      if (v && exp_rdy) begin
        sb.push_back(next_val);
        next_val++;
      end
      afterEdge();
      checkOutput("t3 usage", usage, sb.size());
    end
    checkOutput("t3 budget", pops >= 20, 1);
    while (sb.size() != 0 && cyc < 450) begin
      cyc++;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("t3 drain", data_out, sb[0]);
      void'(sb.pop_front());
      afterEdge();
    end
    checkOutput("t3 empty", empty, 1);

    // Ctrl-flow blocking: J blocks K until J's ack cycle.
    applyBlk(64'hAA, 1'b1, 1'b1, 1'b0);
    checkOutput("t5 push J ready", b_ready, 1);
    afterEdge();
    checkOutput("t5 J head", b_data_out, 64'hAA);
    checkOutput("t5 J cf", b_cf_out, 1);
    applyBlk(64'hBB, 1'b0, 1'b1, 1'b0);
    checkOutput("t5 blocked ready", b_ready, 0);
    afterEdge();
    checkOutput("t5 blocked usage", b_usage, 1);
    applyBlk(64'hBB, 1'b0, 1'b1, 1'b1);
    checkOutput("t5 ack cycle ready", b_ready, 1);
    afterEdge();
    checkOutput("t5 K head", b_data_out, 64'hBB);
    checkOutput("t5 K usage", b_usage, 1);
    checkOutput("t5 K cf", b_cf_out, 0);
    applyBlk('0, 1'b0, 1'b0, 1'b1);
    afterEdge();
    checkOutput("t5 blk empty", b_empty, 1);
    applyBlk('0, 1'b0, 1'b0, 1'b0);

    // Without blocking, pushes continue behind a branch.
    applyStimulus(1'b0, 64'hAA, 1'b1, 1'b1, 1'b0);
    afterEdge();
    applyStimulus(1'b0, 64'hBB, 1'b0, 1'b1, 1'b0);
    checkOutput("t5 noblock ready", ready, 1);
    afterEdge();
    checkOutput("t5 noblock usage", usage, 2);
    checkOutput("t5 noblock cf head", cf_out, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    afterEdge();
    checkOutput("t5 noblock second", data_out, 64'hBB);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    afterEdge();
    checkOutput("t5 noblock empty", empty, 1);

    // Reset mid-traffic with push and pop in the same cycle.
    applyStimulus(1'b0, 64'h11, 1'b0, 1'b1, 1'b0);
    afterEdge();
    applyStimulus(1'b0, 64'h22, 1'b0, 1'b1, 1'b0);
    afterEdge();
    applyStimulus(1'b0, 64'h33, 1'b1, 1'b1, 1'b0);
    afterEdge();
    checkOutput("t6 pre usage", usage, 3);
    applyStimulus(1'b0, 64'h44, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    afterEdge();
    checkOutput("t6 valid", valid_out, 0);
    checkOutput("t6 data", data_out, 0);
    checkOutput("t6 cf", cf_out, 0);
    checkOutput("t6 usage", usage, 0);
    checkOutput("t6 full", full, 0);
    checkOutput("t6 empty", empty, 1);
    @(negedge clk);
    rst = 1'b0; valid_in = 0; ack = 0;
    #1;
    checkOutput("t6 ready", ready, 1);
    applyStimulus(1'b0, 64'h66, 1'b0, 1'b1, 1'b0);
    afterEdge();
    checkOutput("t6 post push", data_out, 64'h66);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
